// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - default sample widths, sample types and the shared saturating shift helper
package fir_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  typedef logic signed [IN_W-1:0]  sample_in_t;
  typedef logic signed [OUT_W-1:0] sample_out_t;

  // Arithmetic right shift of a sign-extended value, then clamp to the signed out_w-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int shift, input int out_w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (s > hi) begin
      sat_shift = hi;
    end else if (s < lo) begin
      sat_shift = lo;
    end else begin
      sat_shift = s;
    end
  endfunction

endpackage

// File: rtl/fir_decimate_requant_if.sv
// rtl/fir_decimate_requant_if.sv - filter sample input stream and rescaled valid/ready output stream
interface fir_decimate_requant_if #(
  parameter int IN_W  = fir_pkg::IN_W,
  parameter int OUT_W = fir_pkg::OUT_W
);
  logic [IN_W-1:0]  in_sample;
  logic             in_valid;
  logic [OUT_W-1:0] out_sample;
  logic             out_valid;
  logic             out_ready;

  modport master (output in_sample, in_valid, out_ready, input out_sample, out_valid);
  modport slave  (input in_sample, in_valid, out_ready, output out_sample, out_valid);
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word-fall-through FIFO with a registered head and explicit level
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wready,
  input  logic                     ready,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             accept;

  assign valid  = (level != '0);
  assign pop    = valid && ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign wready = (level != LVL_FULL) || pop;
  assign accept = push && wready;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !accept) begin
        level <= level - 1'b1;
      end
      // Head follows the write when the FIFO is (or becomes) empty, else the next stored entry.
      if (accept && (level == '0 || (pop && level == LVL_ONE))) begin
        head <= wdata;
      end else if (pop && level > LVL_ONE) begin
        head <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: rtl/fir_decimate_requant.sv
// rtl/fir_decimate_requant.sv - decimate FIR output, requantize (shift/saturate) and buffer it
// Define FIR_DEC_ROUND_EN to round half up before the shift; otherwise the shift floors.
module fir_decimate_requant #(
  parameter int IN_W  = fir_pkg::IN_W,
  parameter int OUT_W = fir_pkg::OUT_W,
  parameter int DECIM = 4,
  parameter int PHASE = 0,
  parameter int SHIFT = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_decimate_requant_if.slave  bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clear_stats
);
  import fir_pkg::*;

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0] PH_KEEP = PH_W'(PHASE);
`ifdef FIR_DEC_ROUND_EN
  localparam logic signed [IN_W:0] ROUND = (IN_W+1)'((SHIFT == 0) ? 0 : 1) << ((SHIFT == 0) ? 0 : SHIFT - 1);
`else
  localparam logic signed [IN_W:0] ROUND = '0;
`endif

  logic [PH_W-1:0]       phase;
  logic                  keep;
  logic signed [IN_W:0]  biased;
  logic                  s1_valid;
  logic [OUT_W-1:0]      s1_data;
  logic                  fifo_wready;
  logic                  drop;

  assign keep = bus.in_valid && (phase == PH_KEEP);
  // One guard bit keeps the rounding add from wrapping near full scale.
  assign biased = $signed({bus.in_sample[IN_W-1], bus.in_sample}) + ROUND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (bus.in_valid) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
      s1_valid <= keep;
      if (keep) begin
        s1_data <= OUT_W'(sat_shift({{(63-IN_W){biased[IN_W]}}, biased}, SHIFT, OUT_W));
      end
    end
  end

  sample_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (s1_valid),
    .wdata  (s1_data),
    .wready (fifo_wready),
    .ready  (bus.out_ready),
    .head   (bus.out_sample),
    .valid  (bus.out_valid),
    .level  (fifo_level)
  );

  assign drop = s1_valid && !fifo_wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimate_requant.sv
// tb/tb_fir_decimate_requant.sv - self-checking bench: vector table, corner sequences, random scoreboard
module tb_fir_decimate_requant;
  import fir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clr_a, clr_b;
  logic [3:0]  level_a, level_b;
  logic        ovf_a, ovf_b;
  logic [15:0] dc_a, dc_b;

  fir_decimate_requant_if #(.IN_W(32), .OUT_W(16)) bus_a ();
  fir_decimate_requant_if #(.IN_W(32), .OUT_W(16)) bus_b ();

  fir_decimate_requant #(.DECIM(4), .PHASE(0), .SHIFT(16), .DEPTH(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .fifo_level(level_a),
    .overflow(ovf_a), .drop_count(dc_a), .clear_stats(clr_a));

  fir_decimate_requant #(.DECIM(1), .PHASE(0), .SHIFT(12), .DEPTH(8), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .fifo_level(level_b),
    .overflow(ovf_b), .drop_count(dc_b), .clear_stats(clr_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference requantizer: plain integer arithmetic on the sample value.
  function automatic logic [15:0] requant(input logic [31:0] x, input int shift);
    longint v;
    v = longint'($signed(x));
`ifdef FIR_DEC_ROUND_EN
    if (shift > 0) v = v + (longint'(1) << (shift - 1));
`endif
    v = v >>> shift;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input bit sel_b, output logic [15:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (sel_b ? bus_b.out_valid : bus_a.out_valid) begin
        ok = 1'b1;
        v  = sel_b ? bus_b.out_sample : bus_a.out_sample;
      end
    end
    if (ok) begin
      if (sel_b) bus_b.out_ready = 1'b1;
      else       bus_a.out_ready = 1'b1;
      step();
      bus_a.out_ready = 1'b0;
      bus_b.out_ready = 1'b0;
    end
  endtask

  task automatic expect_pop(input bit sel_b, input string name, input logic [15:0] exp);
    logic [15:0] v;
    bit ok;
    pop_one(sel_b, v, ok);
    check({name, " present"}, 32'(ok), 32'd1);
    if (ok) check(name, 32'(v), 32'(exp));
  endtask

  typedef struct {
    sample_in_t  x;
    bit          on_b;
    logic [15:0] exp_rnd;
    logic [15:0] exp_trn;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] got[$];
  logic [15:0] q[$];
  logic [15:0] exp;
  logic [31:0] x;
  int          first;
  int          idx;

  initial begin
    vecs[0] = '{32'h0001_8000, 1'b0, 16'h0002, 16'h0001};
    vecs[1] = '{32'hFFFF_8000, 1'b0, 16'h0000, 16'hFFFF};
    vecs[2] = '{32'h7FFF_8000, 1'b0, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{32'h8000_0000, 1'b0, 16'h8000, 16'h8000};
    vecs[4] = '{32'h1234_5678, 1'b0, 16'h1234, 16'h1234};
    vecs[5] = '{32'h1000_0000, 1'b1, 16'h7FFF, 16'h7FFF};
    vecs[6] = '{32'hF000_0000, 1'b1, 16'h8000, 16'h8000};
    vecs[7] = '{32'h0000_0800, 1'b1, 16'h0001, 16'h0000};
    vecs[8] = '{32'hFFFF_F800, 1'b1, 16'h0000, 16'hFFFF};
    vecs[9] = '{32'h07FF_F000, 1'b1, 16'h7FFF, 16'h7FFF};

    reset = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_sample = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sample = '0; bus_b.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset out_sample", 32'(bus_a.out_sample), 32'd0);
    check("reset level", 32'(level_a), 32'd0);
    check("reset overflow", 32'(ovf_a), 32'd0);
    check("reset drop_count", 32'(dc_a), 32'd0);
    check("reset b level", 32'(level_b), 32'd0);
    reset = 1'b0;

    // Decimation ramp and first-output latency
    bus_a.out_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 24; c++) begin
      bus_a.in_valid  = (c < 16);
      bus_a.in_sample = 32'(c) << 16;
      @(negedge clk);
      if (bus_a.out_valid && first < 0) first = c;
      if (bus_a.out_valid && bus_a.out_ready) got.push_back(bus_a.out_sample);
      step();
    end
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b0;
    check("ramp latency", 32'(first), 32'd2);
    check("ramp count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (got.size() > k) check($sformatf("ramp out%0d", k), 32'(got[k]), 32'(4 * k));
    end

    // Requantization vectors
    foreach (vecs[i]) begin
`ifdef FIR_DEC_ROUND_EN
      exp = vecs[i].exp_rnd;
`else
      exp = vecs[i].exp_trn;
`endif
      if (vecs[i].on_b) begin
        bus_b.in_valid = 1'b1; bus_b.in_sample = vecs[i].x; step();
        bus_b.in_valid = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          bus_a.in_valid = 1'b1; bus_a.in_sample = (k == 0) ? vecs[i].x : 32'h0; step();
        end
        bus_a.in_valid = 1'b0;
      end
      expect_pop(vecs[i].on_b, $sformatf("vec%0d", i), exp);
    end

    // Overflow: 10 samples into 8 entries with the consumer stalled
    for (int i = 1; i <= 10; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_sample = 32'(i) << 12; step();
    end
    bus_b.in_valid = 1'b0;
    step(); step();
    check("full level", 32'(level_b), 32'd8);
    check("full overflow", 32'(ovf_b), 32'd1);
    check("full drop_count", 32'(dc_b), 32'd2);
    for (int i = 1; i <= 8; i++) expect_pop(1'b1, $sformatf("drain%0d", i), 16'(i));
    check("drained level", 32'(level_b), 32'd0);

    // Full FIFO: push lands on the same edge as a pop
    for (int i = 11; i <= 18; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_sample = 32'(i) << 12; step();
    end
    bus_b.in_valid = 1'b0;
    step(); step();
    bus_b.in_valid = 1'b1; bus_b.in_sample = 32'(19) << 12; step();
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; step();
    bus_b.out_ready = 1'b0;
    check("push+pop level", 32'(level_b), 32'd8);
    check("push+pop drop_count", 32'(dc_b), 32'd2);
    for (int i = 12; i <= 19; i++) expect_pop(1'b1, $sformatf("order%0d", i), 16'(i));

    // clear_stats alone, then coinciding with a drop
    clr_b = 1'b1; step(); clr_b = 1'b0;
    check("clear overflow", 32'(ovf_b), 32'd0);
    check("clear drop_count", 32'(dc_b), 32'd0);
    for (int i = 20; i <= 27; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_sample = 32'(i) << 12; step();
    end
    bus_b.in_valid = 1'b0;
    step(); step();
    bus_b.in_valid = 1'b1; bus_b.in_sample = 32'(28) << 12; step();
    bus_b.in_valid = 1'b0; clr_b = 1'b1; step();
    clr_b = 1'b0;
    check("clear+drop overflow", 32'(ovf_b), 32'd1);
    check("clear+drop drop_count", 32'(dc_b), 32'd1);
    for (int i = 20; i <= 22; i++) expect_pop(1'b1, $sformatf("pre-reset%0d", i), 16'(i));
    check("pre-reset level", 32'(level_b), 32'd5);

    // Asynchronous reset between edges with data buffered and a sample in flight
    for (int k = 0; k < 2; k++) begin
      bus_a.in_valid = 1'b1; bus_a.in_sample = 32'h0063_0000; step();
    end
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset level", 32'(level_b), 32'd0);
    check("async reset out_valid", 32'(bus_b.out_valid), 32'd0);
    check("async reset overflow", 32'(ovf_b), 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_a.in_valid  = (k != 1);
      bus_a.in_sample = 32'(k + 5) << 16;
      step();
    end
    bus_a.in_valid = 1'b0;
    expect_pop(1'b0, "post-reset first", 16'd5);
    step(); step();
    check("post-reset level", 32'(level_a), 32'd0);

    // Randomized traffic against the reference model; stalls never exceed two cycles
    idx = 0;
    for (int c = 0; c < 420; c++) begin
      x = $urandom;
      bus_a.in_valid  = (c < 400) && ($urandom_range(0, 1) == 1);
      bus_a.in_sample = x;
      bus_a.out_ready = (c >= 400) || (c % 3 == 0) || ($urandom_range(0, 1) == 1);
      if (bus_a.in_valid) begin
        if (idx % 4 == 0) q.push_back(requant(x, 16));
        idx++;
      end
      @(negedge clk);
      if (bus_a.out_valid && bus_a.out_ready) begin
        check("rand model has entry", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check("rand sample", 32'(bus_a.out_sample), 32'(q.pop_front()));
      end
      step();
    end
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b0;
    check("rand leftover", 32'(q.size()), 32'd0);
    check("rand drop_count", 32'(dc_a), 32'd0);
    check("rand level", 32'(level_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
